// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM pin sequencer: step/duty constants,
// the shadowed configuration record and the compare/gating helpers.
package pwm_pkg;

    localparam int         PWM_STEPS    = 255;
    localparam logic [7:0] PWM_STEP_MAX = 8'd254;
    localparam logic [7:0] DUTY_FULL    = 8'hFF;
    localparam int         NUM_PINS     = 16;

    // Configuration that is applied to the pins as one coherent set
    typedef struct packed {
        logic [NUM_PINS-1:0] out_en;
        logic [NUM_PINS-1:0] pwm_en;
        logic [7:0]          duty;
    } pwm_cfg_t;

    // Shared waveform: full duty is pinned high so 0xFF never shows a low step
    function automatic logic pwm_compare(input logic [7:0] step, input logic [7:0] duty);
        return (duty == DUTY_FULL) || (step < duty);
    endfunction

    // Pins without PWM enable drive a static 1 whenever they are output-enabled
    function automatic logic [NUM_PINS-1:0] pin_drive(input pwm_cfg_t cfg, input logic raw);
        return cfg.out_en & (~cfg.pwm_en | {NUM_PINS{raw}});
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Divides clk down to one step_tick every PRESCALE cycles; clear holds the
// count at zero so a re-enabled block starts a fresh step.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic step_tick
);

    localparam logic [15:0] CNT_LAST = 16'(PRESCALE - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Tick on the last count of each step, also every cycle when PRESCALE is 1
    always_comb begin
        step_tick = (cnt_q == CNT_LAST);
    end

    // Next count: wrap after the tick, forced to zero while cleared
    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (clear || step_tick) begin
            cnt_d = '0;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_controller.sv
// Drives 16 pins from the SPI configuration bank with one shared PWM
// waveform of 255 steps per period.
// Build option PWM_SHADOW_EN: when defined, configuration is captured only
// at the period wrap; otherwise it passes straight through to the pins.
module pwm_controller
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [7:0]          en_reg_out_7_0,
    input  logic [7:0]          en_reg_out_15_8,
    input  logic [7:0]          en_reg_pwm_7_0,
    input  logic [7:0]          en_reg_pwm_15_8,
    input  logic [7:0]          pwm_duty_cycle,
    output logic [NUM_PINS-1:0] pwm_out,
    output logic                period_start
);

    logic                step_tick;
    logic                wrap;
    logic [7:0]          step_q;
    logic [7:0]          step_d;
    pwm_cfg_t            cfg_in;
    pwm_cfg_t            cfg_next;
    logic [NUM_PINS-1:0] pwm_out_q;
    logic [NUM_PINS-1:0] pwm_out_d;
    logic                period_start_q;
    logic                period_start_d;

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (!ena),
        .step_tick (step_tick)
    );

    // Gather the register bank into one record and detect the period wrap
    always_comb begin
        cfg_in.out_en = {en_reg_out_15_8, en_reg_out_7_0};
        cfg_in.pwm_en = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        cfg_in.duty   = pwm_duty_cycle;
        wrap          = step_tick && (step_q == PWM_STEP_MAX);
    end

    // Step counter: disable wins over the wrap so a re-enable starts at step 0
    always_comb begin
        step_d = step_q;
        if (!ena || wrap) begin
            step_d = '0;
        end else if (step_tick) begin
            step_d = step_q + 8'd1;
        end
    end

    // Step counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= '0;
        end else begin
            step_q <= step_d;
        end
    end

`ifdef PWM_SHADOW_EN
    pwm_cfg_t cfg_q;
    pwm_cfg_t cfg_d;

    // Shadow capture only at the wrap, independent of ena, so pins never glitch
    always_comb begin
        cfg_d = cfg_q;
        if (wrap) begin
            cfg_d = cfg_in;
        end
        cfg_next = cfg_d;
    end

    // Shadow register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= '0;
        end else begin
            cfg_q <= cfg_d;
        end
    end
`else
    // Without shadowing the live register bank feeds the pin logic directly
    always_comb begin
        cfg_next = cfg_in;
    end
`endif

    // Pin drive is computed from next-cycle state so the outputs line up with
    // the registered step/shadow and with the period_start pulse
    always_comb begin
        pwm_out_d      = '0;
        period_start_d = 1'b0;
        if (ena) begin
            pwm_out_d      = pin_drive(cfg_next, pwm_compare(step_d, cfg_next.duty));
            period_start_d = wrap;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out_q      <= '0;
            period_start_q <= 1'b0;
        end else begin
            pwm_out_q      <= pwm_out_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm_out      = pwm_out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_controller.sv
// Directed bench for pwm_controller with PRESCALE = 2 (510 clk per period).
// Expected values are hand-derived from step = sample_index / 2 within a period.
module tb_pwm_controller;

   logic        clk;
   logic        rstN;
   logic        enaIn;
   logic [15:0] outEnIn;
   logic [15:0] pwmEnIn;
   logic [7:0]  dutyIn;
   logic [15:0] pwmOut;
   logic        periodStart;

   int testsRun    = 0;
   int testsFailed = 0;

   pwm_controller #(
      .PRESCALE (2)
   ) dut (
      .clk             (clk),
      .rst_n           (rstN),
      .ena             (enaIn),
      .en_reg_out_7_0  (outEnIn[7:0]),
      .en_reg_out_15_8 (outEnIn[15:8]),
      .en_reg_pwm_7_0  (pwmEnIn[7:0]),
      .en_reg_pwm_15_8 (pwmEnIn[15:8]),
      .pwm_duty_cycle  (dutyIn),
      .pwm_out         (pwmOut),
      .period_start    (periodStart)
   );

   // 10-unit clock; outputs are sampled on the falling edge
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global watchdog so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Counts one comparison and reports it when it disagrees
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drives the whole configuration bank at once
   task automatic applyStimulus(input logic enaV, input logic [15:0] outEn, input logic [15:0] pwmEn, input logic [7:0] duty);
      enaIn   = enaV;
      outEnIn = outEn;
      pwmEnIn = pwmEn;
      dutyIn  = duty;
   endtask

   // Number of falling edges until period_start is seen, -1 on timeout
   task automatic waitPulse(output int count);
      count = -1;
      for (int i = 1; i <= 1000; i++) begin
         @(negedge clk);
         if (periodStart === 1'b1) begin
            count = i;
            break;
         end
      end
   endtask

   // Observes one full period starting at a pulse cycle; optionally changes
   // the duty right after sample changeAt
   task automatic measurePeriod(input int changeAt, input logic [7:0] newDuty,
                                output logic [15:0] andAll, output logic [15:0] orAll,
                                output int bit0High, output int pulses,
                                output logic nextPs, output logic [15:0] nextOut);
      andAll   = 16'hFFFF;
      orAll    = 16'h0000;
      bit0High = 0;
      pulses   = 0;
      for (int n = 0; n < 510; n++) begin
         if (n > 0) @(negedge clk);
         andAll = andAll & pwmOut;
         orAll  = orAll | pwmOut;
         if (pwmOut[0] === 1'b1) bit0High++;
         if (periodStart === 1'b1) pulses++;
         if (n == changeAt) dutyIn = newDuty;
      end
      @(negedge clk);
      nextPs  = periodStart;
      nextOut = pwmOut;
   endtask

   // New configuration, skip the period in which it is captured, then measure
   task automatic runConfig(input string tag, input logic [15:0] outEn, input logic [15:0] pwmEn, input logic [7:0] duty,
                            input int changeAt, input logic [7:0] newDuty,
                            output logic [15:0] andAll, output logic [15:0] orAll,
                            output int bit0High, output int pulses,
                            output logic nextPs, output logic [15:0] nextOut);
      int gap;
      applyStimulus(1'b1, outEn, pwmEn, duty);
      waitPulse(gap);
      checkOutput({tag, "Gap"}, gap, 510);
      measurePeriod(changeAt, newDuty, andAll, orAll, bit0High, pulses, nextPs, nextOut);
   endtask

   initial begin
      logic [15:0] andAll;
      logic [15:0] orAll;
      logic [15:0] nextOut;
      logic [15:0] holdOr;
      logic        nextPs;
      int          bit0High;
      int          pulses;
      int          gap;
      int          holdPulses;

      // Reset with every input at all-ones
      rstN = 1'b0;
      applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 8'hFF);
      repeat (3) @(negedge clk);
      checkOutput("resetOut", pwmOut, 16'h0000);
      checkOutput("resetPulse", periodStart, 1'b0);

      // Release: shadowed build stays dark until the first wrap
      rstN = 1'b1;
      gap  = -1;
      for (int i = 1; i <= 1000; i++) begin
         @(negedge clk);
         if (i == 1) begin
`ifdef PWM_SHADOW_EN
            checkOutput("firstOut", pwmOut, 16'h0000);
`else
            checkOutput("firstOut", pwmOut, 16'hFFFF);
`endif
         end
         if (periodStart === 1'b1) begin
            gap = i;
            break;
         end
      end
      checkOutput("firstPulseGap", gap, 510);
      checkOutput("firstPulseOut", pwmOut, 16'hFFFF);

      // Static drive on pins 15 and 0
      runConfig("static", 16'h8001, 16'h0000, 8'h00, -1, 8'h00, andAll, orAll, bit0High, pulses, nextPs, nextOut);
      checkOutput("staticAnd", andAll, 16'h8001);
      checkOutput("staticOr", orAll, 16'h8001);
      checkOutput("staticNextPs", nextPs, 1'b1);

      // Half duty on the low byte, static high on the upper byte
      runConfig("half", 16'hFFFF, 16'h00FF, 8'h80, -1, 8'h00, andAll, orAll, bit0High, pulses, nextPs, nextOut);
      checkOutput("halfBit0High", bit0High, 256);
      checkOutput("halfAnd", andAll, 16'hFF00);
      checkOutput("halfOr", orAll, 16'hFFFF);
      checkOutput("halfPulses", pulses, 1);
      checkOutput("halfNextPs", nextPs, 1'b1);

      // Duty 0: every PWM pin constantly low
      runConfig("duty0", 16'hFFFF, 16'hFFFF, 8'h00, -1, 8'h00, andAll, orAll, bit0High, pulses, nextPs, nextOut);
      checkOutput("duty0Or", orAll, 16'h0000);

      // Duty 0xFF: constantly high, including across the wrap
      runConfig("dutyFF", 16'hFFFF, 16'hFFFF, 8'hFF, -1, 8'h00, andAll, orAll, bit0High, pulses, nextPs, nextOut);
      checkOutput("dutyFFAnd", andAll, 16'hFFFF);
      checkOutput("dutyFFWrapOut", nextOut, 16'hFFFF);
      checkOutput("dutyFFNextPs", nextPs, 1'b1);

      // Duty 0x40 -> 0xC0 at step 100
      runConfig("mid", 16'hFFFF, 16'hFFFF, 8'h40, 200, 8'hC0, andAll, orAll, bit0High, pulses, nextPs, nextOut);
`ifdef PWM_SHADOW_EN
      checkOutput("midCurHigh", bit0High, 128);
`else
      checkOutput("midCurHigh", bit0High, 311);
`endif
      checkOutput("midNextPs", nextPs, 1'b1);
      measurePeriod(-1, 8'h00, andAll, orAll, bit0High, pulses, nextPs, nextOut);
      checkOutput("midNextHigh", bit0High, 384);

      // Drop ena at step 50
      applyStimulus(1'b1, 16'hFFFF, 16'h00FF, 8'h80);
      waitPulse(gap);
      checkOutput("enaSetupGap", gap, 510);
      for (int n = 1; n <= 100; n++) @(negedge clk);
      checkOutput("enaPreOut", pwmOut, 16'hFFFF);
      enaIn = 1'b0;
      @(negedge clk);
      checkOutput("enaOffOut", pwmOut, 16'h0000);
      holdOr     = 16'h0000;
      holdPulses = 0;
      repeat (20) begin
         @(negedge clk);
         holdOr = holdOr | pwmOut;
         if (periodStart === 1'b1) holdPulses++;
      end
      checkOutput("enaHoldOut", holdOr, 16'h0000);
      checkOutput("enaHoldPulses", holdPulses, 0);

      // Raise ena: restart at step 0 with the held configuration
      enaIn = 1'b1;
      gap   = -1;
      for (int i = 1; i <= 1000; i++) begin
         @(negedge clk);
         if (i == 1) checkOutput("restartOut", pwmOut, 16'hFFFF);
         if (periodStart === 1'b1) begin
            gap = i;
            break;
         end
      end
      checkOutput("restartGap", gap, 510);
      measurePeriod(-1, 8'h00, andAll, orAll, bit0High, pulses, nextPs, nextOut);
      checkOutput("restartBit0High", bit0High, 256);
      checkOutput("restartAnd", andAll, 16'hFF00);

      // Asynchronous reset at step 100, between clock edges
      for (int n = 1; n <= 200; n++) @(negedge clk);
      checkOutput("preResetOut", pwmOut, 16'hFFFF);
      #2 rstN = 1'b0;
      #1;
      checkOutput("asyncResetOut", pwmOut, 16'h0000);
      checkOutput("asyncResetPulse", periodStart, 1'b0);
      @(negedge clk);
      rstN = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/pwm_controller.md
# pwm_controller

Sequences the 16 output pins from the configuration bank written over SPI: per-pin output enables, per-pin PWM enables, and one shared 8-bit duty cycle. The block sits downstream of the SPI register peripheral and drives the chip's output/bidirectional pins. It owns a prescaler and a period counter, and applies configuration only at period boundaries so pins never glitch. It produces one PWM waveform shared by every PWM-enabled pin.

## Interface
- `PRESCALE`, default 12: clk cycles per PWM step. Legal range is 1..65535.
- `clk` in 1: system clock. This block has exactly one clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ena` in 1: block enable. While low, the block is held idle.
- `en_reg_out_7_0` in 8: output enable, pins 7..0.
- `en_reg_out_15_8` in 8: output enable, pins 15..8.
- `en_reg_pwm_7_0` in 8: PWM enable, pins 7..0.
- `en_reg_pwm_15_8` in 8: PWM enable, pins 15..8.
- `pwm_duty_cycle` in 8: shared duty cycle.
- `pwm_out` out 16: pin drive. Bit i corresponds to pin i.
- `period_start` out 1: one-clk pulse marking the start of a PWM period.

## Operation
- Prescaler counts 0..PRESCALE-1. `step_tick` asserts in the cycle where the count equals PRESCALE-1, and the count then wraps to 0.
- Step counter `step` counts 0..254 (255 steps per period) and advances on `step_tick`. A tick at step 254 wraps it to 0. This wrap event is `wrap`.
- Shadow registers hold copies of the 16-bit out-enable, the 16-bit pwm-enable, and the duty. They load from the inputs on `wrap`.
- `pwm_raw` is defined as follows:
  - duty = 0xFF: constant 1.
  - Otherwise: 1 when `step` < duty, else 0.
  - Therefore duty = 0x00 gives constant 0, and duty = N gives N high steps out of 255.
- Per-pin drive: `pwm_out[i]` = shadow_out[i] & (shadow_pwm[i] ? pwm_raw : 1).
- `ena` low behaviour:
  - Prescaler and `step` clear to 0.
  - `pwm_out` and `period_start` are 0.
  - Shadows hold their values.
  - When `ena` returns high, counting restarts at step 0 with the held shadows.
- Input registers may change at any clk. Only the values present on the `wrap` cycle are captured.

## Timing
- Reset values: prescaler 0, `step` 0, shadows 0, `pwm_out` 0x0000, `period_start` 0.
- `pwm_out` and `period_start` are registered, with 1 clk latency from the counter/shadow state.
- `period_start` is high for exactly one clk, in the cycle after the `wrap` edge. The first pulse follows the first wrap after reset.
- Configuration latency:
  - A configuration is visible on `pwm_out` the cycle after the first `wrap` following the input change.
  - Worst case is 255·PRESCALE + 1 clk.
- Period length is 255·PRESCALE clk. High time is duty·PRESCALE clk, except duty 0xFF, which is always high.
- Boundary conditions:
  - Input change in the same cycle as `wrap`: the new value is captured.
  - `ena` falling in the same cycle as `wrap`: `ena` wins. Counters clear, and shadows still load.
  - PRESCALE = 1: `step_tick` is asserted every cycle.
- Reset mid-period: all flops clear immediately (asynchronous), and `pwm_out` goes to 0 without waiting for `clk`.

## Configuration
- Macro: `PWM_SHADOW_EN`.
- Defined: shadow registers load only on `wrap`, as described above.
- Undefined:
  - Shadows are transparent. `pwm_out` follows the inputs with 1 clk latency, and mid-period duty changes take effect immediately.
  - `period_start` behaviour is unchanged.

## Structure
- Package `pwm_pkg` holds:
  - `PWM_STEPS` = 255.
  - `PWM_STEP_MAX` = 8'd254.
  - `DUTY_FULL` = 8'hFF.
  - `NUM_PINS` = 16.
  - A packed struct for the shadowed configuration (out_en[15:0], pwm_en[15:0], duty[7:0]).
- One sub-module, `pwm_prescaler`:
  - Parameterised by PRESCALE.
  - Inputs: clk, rst_n, clear (driven by !ena).
  - Output: `step_tick`.
- Shadow load, step counter, compare and pin gating live in `pwm_controller`.

## Test plan
All scenarios use PRESCALE = 2, so a period is 510 clk.
- Reset check: assert `rst_n` = 0 with all inputs at 0xFF -> `pwm_out` = 0x0000 and `period_start` = 0. Release reset -> `pwm_out` stays 0x0000 until the first `period_start`.
- Static drive: out_en = 0x8001, pwm_en = 0x0000 -> `pwm_out` = 0x8001 starting the cycle `period_start` first pulses, and held constant thereafter.
- Half duty: out_en = 0xFFFF, pwm_en = 0x00FF, duty = 0x80:
  - Bits 7..0 high for 256 clk and low for 254 clk per period.
  - Bits 15..8 constantly 1.
  - `period_start` spaced exactly 510 clk apart.
- Extremes: with all PWM pins enabled, duty = 0x00 -> bits constantly 0. duty = 0xFF -> bits constantly 1 with no low cycle across any wrap.
- Mid-period change (`PWM_SHADOW_EN` defined): duty 0x40 -> 0xC0 at step 100 -> current period high 128 clk, next period high 384 clk. Without the macro, the change takes effect 1 clk after the input edge.
- Enable/reset mid-operation:
  - Drop `ena` at step 50 -> `pwm_out` = 0 the next clk.
  - Raise `ena` -> waveform restarts at step 0 with the prior shadows.
  - Assert `rst_n` at step 100 -> `pwm_out` = 0 asynchronously.
